// File: rtl/branch_sequencer.sv
// branch_sequencer: multi-cycle short-branch controller (Jcc, LOOPx/JCXZ, INTO)
// fetching the displacement, evaluating the condition and redirecting IP.
`default_nettype none

module branch_sequencer #(
  parameter logic [7:0] INTO_VECTOR = 8'd4,
  parameter int         CF_IDX      = 0,
  parameter int         PF_IDX      = 2,
  parameter int         ZF_IDX      = 6,
  parameter int         SF_IDX      = 7,
  parameter int         OF_IDX      = 11
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  opcode,
  input  logic [15:0] flags,
  input  logic [15:0] cx,
  input  logic        abort,
  input  logic        disp_valid,
  input  logic [7:0]  disp,
  input  logic [15:0] ip_next,
  output logic        disp_ready,
  input  logic        flush_ack,
  output logic        flush_req,
  output logic        ip_wr,
  output logic [15:0] ip_wr_data,
  output logic        cx_wr,
  output logic [15:0] cx_wr_data,
  output logic        trap,
  output logic [7:0]  trap_vector,
  output logic        illegal,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    EVAL     = 3'd2,
    REDIRECT = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t      state;
  logic [7:0]  op_r;
  logic [15:0] cx_r;
  logic [15:0] ipn_r;
  logic [7:0]  disp_r;
  logic        cf_r, pf_r, zf_r, sf_r, of_r;

  logic        in_jcc, in_loopx, in_into;
  logic        op_loop_dec, op_into;
  logic        cond_base, jcc_taken, loop_taken, taken;
  logic [15:0] cx_dec;
  logic [15:0] target;

  always_comb begin
    in_jcc      = (opcode[7:4] == 4'h7);
    in_loopx    = (opcode[7:2] == 6'b111000);
    in_into     = (opcode == 8'hCE);
    op_loop_dec = (op_r[7:2] == 6'b111000) && (op_r[1:0] != 2'd3);
    op_into     = (op_r == 8'hCE);
    cx_dec      = cx_r - 16'd1;
    target      = ipn_r + {{8{disp_r[7]}}, disp_r};

    // Jcc: bits [3:1] pick the base condition, bit 0 inverts it
    case (op_r[3:1])
      3'd0:    cond_base = of_r;
      3'd1:    cond_base = cf_r;
      3'd2:    cond_base = zf_r;
      3'd3:    cond_base = cf_r | zf_r;
      3'd4:    cond_base = sf_r;
      3'd5:    cond_base = pf_r;
      3'd6:    cond_base = sf_r ^ of_r;
      default: cond_base = (sf_r ^ of_r) | zf_r;
    endcase
    jcc_taken = cond_base ^ op_r[0];

    case (op_r[1:0])
      2'd0:    loop_taken = (cx_dec != 16'd0) && !zf_r;
      2'd1:    loop_taken = (cx_dec != 16'd0) && zf_r;
      2'd2:    loop_taken = (cx_dec != 16'd0);
      default: loop_taken = (cx_r == 16'd0);
    endcase
    taken = (op_r[7:4] == 4'h7) ? jcc_taken : loop_taken;
  end

  // Handshake/state-qualified outputs are gated by abort so nothing leaks in the abort cycle
  assign busy       = (state != IDLE);
  assign disp_ready = (state == FETCH) && !abort;
  assign flush_req  = (state == REDIRECT) && !abort;
  assign ip_wr      = flush_req && flush_ack;
  assign done       = (state == DONE) && !abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      op_r        <= 8'd0;
      cx_r        <= 16'd0;
      ipn_r       <= 16'd0;
      disp_r      <= 8'd0;
      cf_r        <= 1'b0;
      pf_r        <= 1'b0;
      zf_r        <= 1'b0;
      sf_r        <= 1'b0;
      of_r        <= 1'b0;
      ip_wr_data  <= 16'd0;
      cx_wr       <= 1'b0;
      cx_wr_data  <= 16'd0;
      trap        <= 1'b0;
      trap_vector <= 8'd0;
      illegal     <= 1'b0;
    end else begin
      cx_wr   <= 1'b0;
      trap    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r <= opcode;
            cx_r <= cx;
            cf_r <= flags[CF_IDX];
            pf_r <= flags[PF_IDX];
            zf_r <= flags[ZF_IDX];
            sf_r <= flags[SF_IDX];
            of_r <= flags[OF_IDX];
            if (in_jcc || in_loopx) begin
              state <= FETCH;
            end else if (in_into) begin
              state <= EVAL;
              if (flags[OF_IDX]) begin
                trap        <= 1'b1;
                trap_vector <= INTO_VECTOR;
              end
            end else begin
              state   <= DONE;
              illegal <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (abort) begin
            state <= IDLE;
          end else if (disp_valid) begin
            disp_r <= disp;
            ipn_r  <= ip_next;
            state  <= EVAL;
            if (op_loop_dec) begin
              cx_wr      <= 1'b1;
              cx_wr_data <= cx_dec;
            end
          end
        end
        EVAL: begin
          if (abort) begin
            state <= IDLE;
          end else if (op_into) begin
            state <= DONE;
          end else if (taken) begin
            ip_wr_data <= target;
            state      <= REDIRECT;
          end else begin
            state <= DONE;
          end
        end
        REDIRECT: begin
          if (abort) begin
            state <= IDLE;
          end else if (flush_ack) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_sequencer.sv
// ============================================================================
// Module   : tb_branch_sequencer
// Brief    : Directed checks of branch_sequencer with hand-computed
//            expectations.
// Revision : 1.1
// ============================================================================
`default_nettype none

module tb_branch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  opcode = 8'd0;
    logic [15:0] flags = 16'd0;
    logic [15:0] cx = 16'd0;
    logic        abort = 1'b0;
    logic        disp_valid = 1'b0;
    logic [7:0]  disp = 8'd0;
    logic [15:0] ip_next = 16'd0;
    logic        disp_ready;
    logic        flush_ack = 1'b0;
    logic        flush_req;
    logic        ip_wr;
    logic [15:0] ip_wr_data;
    logic        cx_wr;
    logic [15:0] cx_wr_data;
    logic        trap;
    logic [7:0]  trap_vector;
    logic        illegal;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    branch_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .opcode     (opcode),
        .flags      (flags),
        .cx         (cx),
        .abort      (abort),
        .disp_valid (disp_valid),
        .disp       (disp),
        .ip_next    (ip_next),
        .disp_ready (disp_ready),
        .flush_ack  (flush_ack),
        .flush_req  (flush_req),
        .ip_wr      (ip_wr),
        .ip_wr_data (ip_wr_data),
        .cx_wr      (cx_wr),
        .cx_wr_data (cx_wr_data),
        .trap       (trap),
        .trap_vector(trap_vector),
        .illegal    (illegal),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction through a displacement-fetching opcode; cycle 0 is the start cycle.
    task automatic run_branch(input logic [7:0] op, input logic [15:0] fl, input logic [15:0] cx_in,
                              input logic [7:0] d, input logic [15:0] ipn, input int ack_dly,
                              input logic exp_taken, input logic exp_cxw,
                              input logic [15:0] exp_cx, input logic [15:0] exp_ip);
        start = 1'b1; opcode = op; flags = fl; cx = cx_in;
        tick();
        start = 1'b0; opcode = 8'h00; flags = 16'h0; cx = 16'h0;
        check("fetch_disp_ready", disp_ready, 1'b1);
        check("fetch_busy", busy, 1'b1);
        disp_valid = 1'b1; disp = d; ip_next = ipn;
        tick();
        disp_valid = 1'b0; disp = 8'h00; ip_next = 16'h0;
        check("eval_cx_wr", cx_wr, exp_cxw);
        if (exp_cxw) check("eval_cx_wr_data", cx_wr_data, exp_cx);
        check("eval_disp_ready", disp_ready, 1'b0);
        check("eval_done", done, 1'b0);
        tick();
        check("cx_wr_pulse", cx_wr, 1'b0);
        if (exp_taken) begin
            check("redir_flush_req", flush_req, 1'b1);
            check("redir_ip_wr_data", ip_wr_data, exp_ip);
            for (int i = 0; i < ack_dly; i++) begin
                check("redir_wait_ip_wr", ip_wr, 1'b0);
                check("redir_wait_flush_req", flush_req, 1'b1);
                tick();
            end
            flush_ack = 1'b1;
            #1;
            check("ack_ip_wr", ip_wr, 1'b1);
            tick();
            flush_ack = 1'b0;
            check("done_after_redir", done, 1'b1);
            check("flush_req_dropped", flush_req, 1'b0);
            check("ip_wr_pulse", ip_wr, 1'b0);
        end else begin
            check("nt_done", done, 1'b1);
            check("nt_flush_req", flush_req, 1'b0);
            check("nt_ip_wr", ip_wr, 1'b0);
        end
        tick();
        check("done_pulse", done, 1'b0);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_disp_ready", disp_ready, 1'b0);
        check("rst_flush_req", flush_req, 1'b0);
        check("rst_ip_wr_data", ip_wr_data, 16'h0000);
        check("rst_cx_wr_data", cx_wr_data, 16'h0000);
        check("rst_trap_vector", trap_vector, 8'h00);
        reset_n = 1'b1;
        tick();

        // JE taken, ZF=1, backward displacement, ack two cycles late
        run_branch(8'h74, 16'h0040, 16'h0000, 8'hFE, 16'h1002, 2, 1'b1, 1'b0, 16'h0000, 16'h1000);
        // JNLE with SF=1, OF=0: not taken
        run_branch(8'h7F, 16'h0080, 16'h0000, 8'h10, 16'h3000, 0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        // LOOP cx=1 -> 0, not taken
        run_branch(8'hE2, 16'h0000, 16'h0001, 8'h05, 16'h0400, 0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        // LOOP cx=0 -> FFFF, taken, IP wraps
        run_branch(8'hE2, 16'h0000, 16'h0000, 8'h7F, 16'hFFF0, 0, 1'b1, 1'b1, 16'hFFFF, 16'h006F);
        // LOOPNE cx=5, ZF=1: not taken
        run_branch(8'hE0, 16'h0040, 16'h0005, 8'h20, 16'h0500, 0, 1'b0, 1'b1, 16'h0004, 16'h0000);
        // JCXZ cx=0: taken, no CX write
        run_branch(8'hE3, 16'h0000, 16'h0000, 8'h10, 16'h2000, 1, 1'b1, 1'b0, 16'h0000, 16'h2010);
        // JL with SF=1, OF=0: taken, displacement -128
        run_branch(8'h7C, 16'h0080, 16'h0000, 8'h80, 16'h0100, 0, 1'b1, 1'b0, 16'h0000, 16'h0080);
        // JB with CF=0: not taken
        run_branch(8'h72, 16'h0000, 16'h0000, 8'h04, 16'h0600, 0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        // LOOPE cx=3, ZF=1: taken
        run_branch(8'hE1, 16'h0040, 16'h0003, 8'h02, 16'h0700, 0, 1'b1, 1'b1, 16'h0002, 16'h0702);

        // INTO with OF=1
        start = 1'b1; opcode = 8'hCE; flags = 16'h0800;
        tick();
        start = 1'b0; flags = 16'h0;
        check("into_trap", trap, 1'b1);
        check("into_trap_vector", trap_vector, 8'h04);
        check("into_disp_ready", disp_ready, 1'b0);
        tick();
        check("into_trap_pulse", trap, 1'b0);
        check("into_done", done, 1'b1);
        tick();
        check("into_idle", busy, 1'b0);

        // INTO with OF=0
        start = 1'b1; opcode = 8'hCE; flags = 16'h0000;
        tick();
        start = 1'b0;
        check("into_nt_trap", trap, 1'b0);
        tick();
        check("into_nt_done", done, 1'b1);
        check("into_nt_trap2", trap, 1'b0);
        tick();

        // Unsupported opcode
        start = 1'b1; opcode = 8'h90;
        tick();
        start = 1'b0;
        check("illegal_flag", illegal, 1'b1);
        check("illegal_done", done, 1'b1);
        tick();
        check("illegal_pulse", illegal, 1'b0);
        check("illegal_idle", busy, 1'b0);

        // Displacement stall, then abort in REDIRECT with a simultaneous ack
        start = 1'b1; opcode = 8'h74; flags = 16'h0040;
        tick();
        start = 1'b0; flags = 16'h0;
        for (int i = 0; i < 5; i++) begin
            check("stall_disp_ready", disp_ready, 1'b1);
            tick();
        end
        disp_valid = 1'b1; disp = 8'h08; ip_next = 16'h4000;
        tick();
        disp_valid = 1'b0;
        tick();
        check("abort_pre_flush_req", flush_req, 1'b1);
        check("abort_pre_ip_wr_data", ip_wr_data, 16'h4008);
        abort = 1'b1; flush_ack = 1'b1;
        #1;
        check("abort_ip_wr", ip_wr, 1'b0);
        check("abort_flush_req", flush_req, 1'b0);
        check("abort_done", done, 1'b0);
        tick();
        abort = 1'b0; flush_ack = 1'b0;
        check("abort_idle", busy, 1'b0);
        check("abort_no_done", done, 1'b0);
        check("abort_no_ip_wr", ip_wr, 1'b0);

        // Reset asserted mid-FETCH
        start = 1'b1; opcode = 8'h75;
        tick();
        start = 1'b0;
        check("midrst_pre_ready", disp_ready, 1'b1);
        reset_n = 1'b0;
        #1;
        check("midrst_disp_ready", disp_ready, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ip_wr_data", ip_wr_data, 16'h0000);
        tick();
        reset_n = 1'b1;
        tick();
        check("midrst_still_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
